// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared jump codes, NOP word and fetch FSM state encoding
package fetch_unit_pkg;
    localparam logic [1:0]  JMP_BEQ  = 2'b00;
    localparam logic [1:0]  JMP_BNE  = 2'b01;
    localparam logic [1:0]  JMP_J    = 2'b10;
    localparam logic [1:0]  JMP_NONE = 2'b11;
    localparam logic [31:0] INST_NOP = 32'h0;
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus (req, addr out of fetch; ack, rdata back from memory)
interface fetch_unit_if #(parameter int PC_W = 32);
    logic            req;
    logic [PC_W-1:0] addr;
    logic            ack;
    logic [31:0]     rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit_branch_resolve.sv
// fetch_unit_branch_resolve: decides whether the ID-stage branch/jump redirects fetch
// Ports: stall, id_valid, id_jump_ctl, id_cmp_eq in; taken out (never while stalled)
module fetch_unit_branch_resolve
    import fetch_unit_pkg::*;
(
    input  logic       stall,
    input  logic       id_valid,
    input  logic [1:0] id_jump_ctl,
    input  logic       id_cmp_eq,
    output logic       taken
);
    assign taken = !stall && id_valid &&
                   ((id_jump_ctl == JMP_BEQ && id_cmp_eq) ||
                    (id_jump_ctl == JMP_BNE && !id_cmp_eq) ||
                    id_jump_ctl == JMP_J);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning pc, imem handshake, skid and IF/ID register
// Ports: clk, rst; imem (req/addr/ack/rdata master); stall and ID branch resolution in;
//        ifid_inst, ifid_pc_plus4, ifid_valid out (registered only)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem,
    input  logic              stall,
    input  logic              id_valid,
    input  logic [1:0]        id_jump_ctl,
    input  logic              id_cmp_eq,
    input  logic [PC_W-1:0]   id_target,
    output logic [31:0]       ifid_inst,
    output logic [PC_W-1:0]   ifid_pc_plus4,
    output logic              ifid_valid
);
    fetch_state_t    state, state_d;
    logic            taken;
    logic [PC_W-1:0] pc, pc_plus4, disc_addr, skid_pc_plus4;
    logic [31:0]     skid_inst;

    fetch_unit_branch_resolve u_branch_resolve (
        .stall       (stall),
        .id_valid    (id_valid),
        .id_jump_ctl (id_jump_ctl),
        .id_cmp_eq   (id_cmp_eq),
        .taken       (taken)
    );

    assign pc_plus4 = pc + PC_W'(4);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_FETCH:   state_d = taken ? (imem.ack ? ST_FETCH : ST_DISCARD)
                                        : (imem.ack && stall ? ST_HOLD : ST_FETCH);
            ST_HOLD:    state_d = stall ? ST_HOLD : ST_FETCH;
            ST_DISCARD: state_d = imem.ack ? ST_FETCH : ST_DISCARD;
            default:    state_d = ST_FETCH;
        endcase
    end

    // A redirected-but-unanswered request keeps its old address until the ack is absorbed
    always_comb begin
        imem.req  = !rst && state != ST_HOLD;
        imem.addr = state == ST_DISCARD ? disc_addr : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            disc_addr     <= RESET_PC;
            skid_inst     <= INST_NOP;
            skid_pc_plus4 <= '0;
            ifid_inst     <= INST_NOP;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else if (taken) begin
            // Redirect wins over any word arriving or waiting in the skid
            pc         <= id_target;
            ifid_inst  <= INST_NOP;
            ifid_valid <= 1'b0;
            if (state == ST_FETCH) disc_addr <= pc;
        end else if (state == ST_FETCH && imem.ack) begin
            pc <= pc_plus4;
            if (stall) begin
                skid_inst     <= imem.rdata;
                skid_pc_plus4 <= pc_plus4;
            end else begin
                ifid_inst     <= imem.rdata;
                ifid_pc_plus4 <= pc_plus4;
                ifid_valid    <= 1'b1;
            end
        end else if (state == ST_FETCH && !stall) begin
            // Decode moves on with no new word: hand it a bubble so nothing is re-issued
            ifid_inst  <= INST_NOP;
            ifid_valid <= 1'b0;
        end else if (state == ST_HOLD && !stall) begin
            ifid_inst     <= skid_inst;
            ifid_pc_plus4 <= skid_pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a transaction-level fetch model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, id_valid, id_cmp_eq;
    logic [1:0]  id_jump_ctl;
    logic [31:0] id_target, ifid_inst, ifid_pc_plus4;
    logic        ifid_valid;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit_if #(.PC_W(32)) imem ();

    fetch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem),
        .stall         (stall),
        .id_valid      (id_valid),
        .id_jump_ctl   (id_jump_ctl),
        .id_cmp_eq     (id_cmp_eq),
        .id_target     (id_target),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

    always #5 clk = ~clk;

    // Reference model: next pc, an owed (to-be-dropped) request, a queue of captured words, IF/ID
    logic [31:0] m_pc = 32'h0;
    bit          m_owe = 1'b0;
    logic [31:0] m_owe_addr = 32'h0;
    logic [63:0] m_skid[$];
    logic [31:0] m_inst = 32'h0, m_pp4 = 32'h0;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit a, input bit s, input bit v, input bit [1:0] c, input bit e,
                        input logic [31:0] t, input bit r);
        bit          taken, exp_req;
        logic [31:0] exp_addr, w;
        @(negedge clk);
        exp_req  = !r && m_skid.size() == 0;
        exp_addr = m_owe ? m_owe_addr : m_pc;
        rst = r; stall = s; id_valid = v; id_jump_ctl = c; id_cmp_eq = e; id_target = t;
        imem.ack = a; imem.rdata = mem(exp_addr);
        #1;
        chk("imem_req", 32'(imem.req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem.addr, exp_addr);
        taken = !s && v && ((c == 2'd0 && e) || (c == 2'd1 && !e) || c == 2'd2);
        if (r) begin
            m_pc = 32'h0; m_owe = 0; m_skid.delete();
            m_inst = 0; m_pp4 = 0; m_valid = 0;
        end else if (m_skid.size() != 0) begin
            if (!s) begin
                if (taken) begin m_inst = 0; m_valid = 0; m_pc = t; end
                else begin {m_inst, m_pp4} = m_skid[0]; m_valid = 1; end
                m_skid.delete();
            end
        end else if (m_owe) begin
            if (taken) m_pc = t;
            if (a) m_owe = 0;
        end else if (taken) begin
            m_inst = 0; m_valid = 0;
            if (!a) begin m_owe = 1; m_owe_addr = m_pc; end
            m_pc = t;
        end else if (a) begin
            w = mem(m_pc);
            if (s) m_skid.push_back({w, m_pc + 32'd4});
            else begin m_inst = w; m_pp4 = m_pc + 32'd4; m_valid = 1; end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_inst = 0; m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("ifid_inst", ifid_inst, m_inst);
        chk("ifid_pc_plus4", ifid_pc_plus4, m_pp4);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    endtask

    initial begin
        rst = 1; stall = 0; id_valid = 0; id_jump_ctl = 2'b11; id_cmp_eq = 0; id_target = 0;
        imem.ack = 0; imem.rdata = 0;
        // reset, then back-to-back same-cycle acks
        step(0, 0, 0, 2'b11, 0, 0, 1);
        step(0, 0, 0, 2'b11, 0, 0, 1);
        chk("reset_valid", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 2'b11, 0, 0, 0);
        chk("seq_pc_plus4", ifid_pc_plus4, 32'd20);
        // late ack under stall -> hold, release
        step(0, 0, 0, 2'b11, 0, 0, 0);
        step(1, 1, 0, 2'b11, 0, 0, 0);
        step(0, 1, 0, 2'b11, 0, 0, 0);
        step(0, 1, 0, 2'b11, 0, 0, 0);
        step(0, 0, 0, 2'b11, 0, 0, 0);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        // beq taken with same-cycle ack, then bne with eq=1 not taken
        step(1, 0, 1, 2'b00, 1, 32'h40, 0);
        step(1, 0, 1, 2'b01, 1, 32'h80, 0);
        step(1, 0, 1, 2'b01, 1, 32'h80, 0);
        chk("bne_not_taken", ifid_pc_plus4, 32'h48);
        // jump while request pending at 0x20 -> discard old ack
        step(1, 0, 1, 2'b10, 0, 32'h20, 0);
        step(0, 0, 1, 2'b10, 0, 32'h100, 0);
        step(0, 0, 0, 2'b11, 0, 0, 0);
        step(0, 0, 0, 2'b11, 0, 0, 0);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        chk("after_discard", ifid_pc_plus4, 32'h104);
        // redirect ignored under stall, taken once released
        step(0, 1, 1, 2'b10, 0, 32'h200, 0);
        step(0, 0, 1, 2'b10, 0, 32'h200, 0);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        // reset mid-request at 0x80 with ack during reset
        step(1, 0, 1, 2'b10, 0, 32'h80, 0);
        step(0, 0, 0, 2'b11, 0, 0, 0);
        step(1, 0, 0, 2'b11, 0, 0, 1);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        // pc wrap at the top of the address space
        step(1, 0, 1, 2'b10, 0, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        chk("wrap_pc_plus4", ifid_pc_plus4, 32'h0);
        step(1, 0, 0, 2'b11, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 99) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
